// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: request size codes, FSM
// states and the default RAM window size.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int RAM_REGION_BITS_DEFAULT = 10;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SZ_RSVD) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract + sign/zero extend, and store
// replicate / read-modify-write merge of a sub-word into a bus word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_word,
  output logic [31:0] replicated_word,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [3:0]  lane_hit;

  always_comb begin
    byte_val  = rdata[{lane, 3'b000} +: 8];
    half_val  = lane[1] ? rdata[31:16] : rdata[15:0];
    load_word = rdata;
    case (size)
      SZ_BYTE: load_word = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: load_word = {{16{sign_ext & half_val[15]}}, half_val};
      default: load_word = rdata;
    endcase
  end

  always_comb begin
    replicated_word = wdata;
    lane_hit        = 4'b1111;
    case (size)
      SZ_BYTE: begin
        replicated_word = {4{wdata[7:0]}};
        lane_hit        = 4'b0000;
        lane_hit[lane]  = 1'b1;
      end
      SZ_HALF: begin
        replicated_word = {2{wdata[15:0]}};
        lane_hit        = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        replicated_word = wdata;
        lane_hit        = 4'b1111;
      end
    endcase
  end

  // Replicated data already sits in every lane, so the merge is a per-lane pick.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = lane_hit[gi] ? replicated_word[8*gi +: 8]
                                                   : rdata[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end: maps byte/half/word CPU loads and stores onto a
// word-only bus, with read-modify-write for sub-word RAM stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_REGION_BITS = RAM_REGION_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_exc,
  output logic [31:0] bad_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_reg, state_next;
  logic [1:0]  size_eff;
  logic        misaligned, is_ram, sub_word;
  logic        accept, do_load, do_store, rmw_start, misalign_hit;
  logic [31:0] word_addr;
  logic [31:0] load_word, replicated_word, merged_word;

  logic [31:0] load_data_reg;
  logic        load_valid_reg;
  logic        misalign_exc_reg;
  logic [31:0] bad_addr_reg;
  logic [31:0] rmw_addr_reg;
  logic [31:0] rmw_data_reg;

  assign size_eff   = norm_size(req_size);
  assign misaligned = ((size_eff == SZ_HALF) && req_addr[0]) ||
                      ((size_eff == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign is_ram     = (req_addr[31:RAM_REGION_BITS] == '0);
  assign sub_word   = (size_eff != SZ_WORD);
  assign word_addr  = {req_addr[31:2], 2'b00};

  // Requests arriving during RMW_WR belong to the bubble slot and are dropped.
  assign accept       = (state_reg == ST_IDLE) && req_valid;
  assign misalign_hit = accept && misaligned;
  assign do_load      = accept && !misaligned && !req_wr;
  assign do_store     = accept && !misaligned && req_wr;
  assign rmw_start    = do_store && sub_word && is_ram;

  mem_lane_align u_lane_align (
    .size            (size_eff),
    .sign_ext        (req_signed),
    .lane            (req_addr[1:0]),
    .rdata           (mem_rdata),
    .wdata           (req_wdata),
    .load_word       (load_word),
    .replicated_word (replicated_word),
    .merged_word     (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = rmw_start ? ST_RMW_WR : ST_IDLE;
      ST_RMW_WR: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bus strobes are gated by reset so an interrupted RMW never writes.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    stall     = 1'b0;
    mem_addr  = word_addr;
    mem_wdata = replicated_word;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (do_load) begin
            mem_rd = 1'b1;
          end else if (rmw_start) begin
            mem_rd = 1'b1;
            stall  = 1'b1;
          end else if (do_store) begin
            mem_wr = 1'b1;
          end
        end
        ST_RMW_WR: begin
          mem_wr    = 1'b1;
          mem_addr  = rmw_addr_reg;
          mem_wdata = rmw_data_reg;
        end
        default: begin
          mem_rd = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data_reg    <= '0;
      load_valid_reg   <= 1'b0;
      misalign_exc_reg <= 1'b0;
      bad_addr_reg     <= '0;
      rmw_addr_reg     <= '0;
      rmw_data_reg     <= '0;
    end else begin
      load_valid_reg   <= do_load;
      misalign_exc_reg <= misalign_hit;
      if (do_load) begin
        load_data_reg <= load_word;
      end
      if (misalign_hit) begin
        bad_addr_reg <= req_addr;
      end
      if (rmw_start) begin
        rmw_addr_reg <= word_addr;
        rmw_data_reg <= merged_word;
      end
    end
  end

  assign load_data    = load_data_reg;
  assign load_valid   = load_valid_reg;
  assign misalign_exc = misalign_exc_reg;
  assign bad_addr     = bad_addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array RAM reference model,
// directed scenarios and randomized load/store traffic.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_exc;
  logic [31:0] bad_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] bus_mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_load_data = 32'd0;
  logic [31:0] exp_bad = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_REGION_BITS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_exc (misalign_exc),
    .bad_addr     (bad_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [31:0] periph_word(input logic [31:0] a);
    return 32'hC3A5_0000 ^ a;
  endfunction

  assign mem_rdata = (mem_addr[31:10] == 22'd0) ? bus_mem[mem_addr[9:2]] : periph_word(mem_addr);

  always @(posedge clk) begin
    if (mem_wr && (mem_addr[31:10] == 22'd0)) bus_mem[mem_addr[9:2]] <= mem_wdata;
  end

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int ia;
    ia = int'(addr & 32'hFFFF_FFFC);
    if (addr < 32'd1024) return {ref_mem[ia+3], ref_mem[ia+2], ref_mem[ia+1], ref_mem[ia]};
    return periph_word(addr & 32'hFFFF_FFFC);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic sgn);
    logic [31:0] sh;
    sh = model_word(addr) >> (8 * addr[1:0]);
    if (size == 2'd0) return sgn ? 32'($signed(sh[7:0])) : {24'd0, sh[7:0]};
    if (size == 2'd1) return sgn ? 32'($signed(sh[15:0])) : {16'd0, sh[15:0]};
    return model_word(addr);
  endfunction

  // One CPU request, including the bubble cycle of a RAM read-modify-write.
  task automatic run_txn(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_wr_addr, output logic [31:0] got_wr_data,
                         output logic got_rd, output logic got_stall);
    logic mis, ram, sub, rmw, e_rd, e_wr, e_st;
    logic [31:0] e_wdata;
    int nb;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis  = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0);
    ram  = addr < 32'd1024;
    sub  = size < 2'd2;
    rmw  = wr && sub && ram && !mis;
    e_rd = !mis && (!wr || rmw);
    e_wr = !mis && wr && !rmw;
    e_st = rmw;
    e_wdata = (size == 2'd0) ? {4{wdata[7:0]}} : (size == 2'd1) ? {2{wdata[15:0]}} : wdata;
    got_wr_addr = 32'd0;
    got_wr_data = 32'd0;
    $display("txn wr=%0d size=%0d sgn=%0d addr=%08h wdata=%08h", wr, size, sgn, addr, wdata);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    #1;
    got_rd = mem_rd;
    got_stall = stall;
    n_cmp++;
    if ({mem_rd, mem_wr, stall} !== {e_rd, e_wr, e_st}) begin
      n_bad++;
      $display("FAIL strobes addr=%08h rd/wr/stall got %b%b%b want %b%b%b",
               addr, mem_rd, mem_wr, stall, e_rd, e_wr, e_st);
    end
    if (e_rd || e_wr) begin
      n_cmp++;
      if (mem_addr !== (addr & 32'hFFFF_FFFC)) begin
        n_bad++;
        $display("FAIL mem_addr got %08h want %08h", mem_addr, addr & 32'hFFFF_FFFC);
      end
    end
    if (e_wr) begin
      got_wr_addr = mem_addr;
      got_wr_data = mem_wdata;
      n_cmp++;
      if (mem_wdata !== e_wdata) begin
        n_bad++;
        $display("FAIL mem_wdata addr=%08h got %08h want %08h", addr, mem_wdata, e_wdata);
      end
    end
    if (!mis && !wr) exp_load_data = model_load(addr, size, sgn);
    if (mis) exp_bad = addr;
    if (!mis && wr && ram) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({load_valid, misalign_exc} !== {!mis && !wr, mis}) begin
      n_bad++;
      $display("FAIL pulses addr=%08h valid/exc got %b%b want %b%b",
               addr, load_valid, misalign_exc, !mis && !wr, mis);
    end
    n_cmp++;
    if (load_data !== exp_load_data || bad_addr !== exp_bad) begin
      n_bad++;
      $display("FAIL regs addr=%08h load_data got %08h want %08h bad_addr got %08h want %08h",
               addr, load_data, exp_load_data, bad_addr, exp_bad);
    end
    if (rmw) begin
      // Bubble slot: whatever the CPU presents here must be ignored.
      @(negedge clk);
      req_valid = 1'($urandom); req_wr = 1'($urandom); req_size = 2'($urandom);
      req_addr = 32'($urandom_range(0, 1023)); req_wdata = $urandom;
      #1;
      got_wr_addr = mem_addr;
      got_wr_data = mem_wdata;
      n_cmp++;
      if ({mem_rd, mem_wr, stall} !== 3'b010 || mem_addr !== (addr & 32'hFFFF_FFFC) ||
          mem_wdata !== model_word(addr)) begin
        n_bad++;
        $display("FAIL rmw_write rd/wr/stall got %b%b%b addr %08h data %08h want 010 %08h %08h",
                 mem_rd, mem_wr, stall, mem_addr, mem_wdata, addr & 32'hFFFF_FFFC,
                 model_word(addr));
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({load_valid, misalign_exc} !== 2'b00 || bad_addr !== exp_bad ||
          load_data !== exp_load_data) begin
        n_bad++;
        $display("FAIL bubble_ignored valid/exc got %b%b bad_addr %08h load_data %08h",
                 load_valid, misalign_exc, bad_addr, load_data);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_rd, mem_wr, stall, load_valid, misalign_exc} !== 5'b0 ||
        load_data !== 32'd0 || bad_addr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state rd/wr/stall/valid/exc got %b%b%b%b%b load_data %08h bad_addr %08h",
               mem_rd, mem_wr, stall, load_valid, misalign_exc, load_data, bad_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_preload;
    logic [31:0] wa, wd, a, d;
    logic r, s;
    for (int i = 0; i < 256; i++) begin
      wa = 32'(i * 4);
      wd = (i == 4) ? 32'h8899AABB : $urandom;
      run_txn(1'b1, 2'd2, 1'b0, wa, wd, a, d, r, s);
    end
  endtask

  task automatic test_load_extend;
    logic [31:0] a, d;
    logic r, s;
    run_txn(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, a, d, r, s);
    n_cmp++;
    if (load_data !== 32'hFFFFFFAA) begin
      n_bad++; $display("FAIL lb_signed got %08h want FFFFFFAA", load_data);
    end
    run_txn(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, a, d, r, s);
    n_cmp++;
    if (load_data !== 32'h000000AA) begin
      n_bad++; $display("FAIL lbu got %08h want 000000AA", load_data);
    end
    run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, a, d, r, s);
    n_cmp++;
    if (load_data !== 32'hFFFF8899) begin
      n_bad++; $display("FAIL lh_signed got %08h want FFFF8899", load_data);
    end
  endtask

  task automatic test_rmw_store;
    logic [31:0] a, d;
    logic r, s;
    run_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFF_FF5C, a, d, r, s);
    n_cmp++;
    if (r !== 1'b1 || s !== 1'b1 || a !== 32'h10 || d !== 32'h5C99AABB) begin
      n_bad++;
      $display("FAIL sb_rmw rd=%b stall=%b wr_addr=%08h wr_data=%08h want 1 1 00000010 5C99AABB",
               r, s, a, d);
    end
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, a, d, r, s);
    n_cmp++;
    if (load_data !== 32'h5C99AABB) begin
      n_bad++; $display("FAIL sb_readback got %08h want 5C99AABB", load_data);
    end
  endtask

  task automatic test_periph_store;
    logic [31:0] a, d;
    logic r, s;
    run_txn(1'b1, 2'd1, 1'b0, 32'h4000_0002, 32'hABCD_1234, a, d, r, s);
    n_cmp++;
    if (r !== 1'b0 || s !== 1'b0 || a !== 32'h4000_0000 || d !== 32'h12341234) begin
      n_bad++;
      $display("FAIL sh_periph rd=%b stall=%b wr_addr=%08h wr_data=%08h want 0 0 40000000 12341234",
               r, s, a, d);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] a, d;
    logic r, s;
    run_txn(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, a, d, r, s);
    n_cmp++;
    if (r !== 1'b0 || bad_addr !== 32'h22 || misalign_exc !== 1'b1 || load_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lw_misaligned rd=%b exc=%b valid=%b bad_addr=%08h want 0 1 0 00000022",
               r, misalign_exc, load_valid, bad_addr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (misalign_exc !== 1'b0) begin
      n_bad++; $display("FAIL exc_pulse got %b want 0", misalign_exc);
    end
  endtask

  task automatic test_random;
    logic [31:0] addr, a, d;
    logic [1:0] size;
    logic r, s;
    for (int i = 0; i < 400; i++) begin
      size = 2'($urandom);
      if ($urandom_range(0, 5) == 0) addr = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
      else addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        else if (size >= 2'd2) addr[1:0] = 2'b00;
      end
      run_txn(1'($urandom), size, 1'($urandom), addr, $urandom, a, d, r, s);
    end
  endtask

  task automatic test_reset_mid_rmw;
    logic [31:0] pre, a, d;
    logic r, s;
    pre = model_word(32'h104);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h105; req_wdata = ~pre;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_rd, mem_wr, stall, load_valid, misalign_exc} !== 5'b0 || load_data !== 32'd0 ||
        bad_addr !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_rmw rd/wr/stall/valid/exc got %b%b%b%b%b load_data %08h bad_addr %08h",
               mem_rd, mem_wr, stall, load_valid, misalign_exc, load_data, bad_addr);
    end
    exp_load_data = 32'd0;
    exp_bad = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    run_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, a, d, r, s);
    n_cmp++;
    if (load_data !== pre) begin
      n_bad++; $display("FAIL rmw_lost got %08h want %08h", load_data, pre);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_load_extend();
    test_rmw_store();
    test_periph_store();
    test_misalign();
    test_random();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
